tp_final_top: RTL and testbench

//  Board-level top: UART serial link with LED status display.
//  - Receives 8N1 UART frames on rx.
//  - Shows the last good byte on led[7:0].
//  - Echoes every good byte back on tx.
//  - Contains baud timing, RX deserializer, 1-byte echo buffer, TX serializer.

---
 rtl/tp_final_top.sv | 244 ++++++++++++++++++++++++
 tb/tb_tp_final_top.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/tp_final_top.sv
// tp_final_top
//    Board-level UART echo with LED status display. Incoming 8N1 frames on
//    rx are deserialized. The last correctly framed byte is shown on led and
//    placed in a one-byte echo buffer. The TX serializer sends that buffer
//    back out on tx.
//
// Ports
//    clk    in   1          system clock, all logic on the rising edge
//    reset  in   1          synchronous, active-low reset
//    rx     in   1          UART serial input, idle high
//    tx     out  1          UART serial output, idle high, registered
//    led    out  DATA_BITS  last correctly framed received byte
module tp_final_top #(
   parameter int CLKS_PER_BIT = 32,
   parameter int DATA_BITS    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 rx,
   output logic                 tx,
   output logic [DATA_BITS-1:0] led
);

   localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

   localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_BITS - 1);

   typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

   // rx synchronizer
   logic rx_meta_q, rx_sync_q;

   // RX deserializer
   state_t                 rx_state_q, rx_state_d;
   logic [CW-1:0]          rx_cnt_q, rx_cnt_d;
   logic [IW-1:0]          rx_idx_q, rx_idx_d;
   logic [DATA_BITS-1:0]   rx_shift_q, rx_shift_d;
   logic                   rx_ferr_q, rx_ferr_d;
   logic                   rx_done_q, rx_done_d;

   // LED and echo buffer
   logic [DATA_BITS-1:0]   led_q, led_d;
   logic [DATA_BITS-1:0]   buf_data_q, buf_data_d;
   logic                   buf_full_q, buf_full_d;

   // TX serializer
   state_t                 tx_state_q, tx_state_d;
   logic [CW-1:0]          tx_cnt_q, tx_cnt_d;
   logic [IW-1:0]          tx_idx_q, tx_idx_d;
   logic [DATA_BITS-1:0]   tx_shift_q, tx_shift_d;
   logic                   tx_q, tx_d;
   logic                   tx_load;

   assign tx      = tx_q;
   assign led     = led_q;
   assign tx_load = (tx_state_q == S_IDLE) && buf_full_q;

   // ---------------------------------------------------------------
   // RX: sample mid-bit, starting half a bit after the falling edge
   // ---------------------------------------------------------------
   always_comb begin
      rx_state_d = rx_state_q;
      rx_cnt_d   = rx_cnt_q;
      rx_idx_d   = rx_idx_q;
      rx_shift_d = rx_shift_q;
      rx_ferr_d  = rx_ferr_q;
      rx_done_d  = 1'b0;
      case (rx_state_q)
         S_IDLE: begin
            rx_ferr_d = 1'b0;
            if (!rx_sync_q) begin
               rx_cnt_d   = '0;
               rx_state_d = S_START;
            end
         end
         S_START: begin
            if (rx_cnt_q == HALF_LAST) begin
               rx_cnt_d   = '0;
               rx_idx_d   = '0;
               // a line that is high again at mid-start was only a glitch
               rx_state_d = rx_sync_q ? S_IDLE : S_DATA;
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d   = '0;
               rx_shift_d = {rx_sync_q, rx_shift_q[DATA_BITS-1:1]};
               if (rx_idx_q == IDX_LAST) begin
                  rx_idx_d   = '0;
                  rx_state_d = S_STOP;
               end else begin
                  rx_idx_d = rx_idx_q + IW'(1);
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (rx_ferr_q) begin
               // framing error: hold off until the line returns to idle
               if (rx_sync_q) rx_state_d = S_IDLE;
            end else if (rx_cnt_q == BIT_LAST) begin
               rx_cnt_d = '0;
               if (rx_sync_q) begin
                  rx_done_d  = 1'b1;
                  rx_state_d = S_IDLE;
               end else begin
                  rx_ferr_d = 1'b1;
               end
            end else begin
               rx_cnt_d = rx_cnt_q + CW'(1);
            end
         end
         default: rx_state_d = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------
   // LED and echo buffer: a new byte always wins over a pending one
   // ---------------------------------------------------------------
   always_comb begin
      led_d      = led_q;
      buf_data_d = buf_data_q;
      buf_full_d = buf_full_q;
      if (tx_load) buf_full_d = 1'b0;
      if (rx_done_q) begin
         led_d      = rx_shift_q;
         buf_data_d = rx_shift_q;
         buf_full_d = 1'b1;
      end
   end

   // ---------------------------------------------------------------
   // TX: tx_d carries the level of the state being entered, so each
   // bit is held for exactly CLKS_PER_BIT clocks
   // ---------------------------------------------------------------
   always_comb begin
      tx_state_d = tx_state_q;
      tx_cnt_d   = tx_cnt_q;
      tx_idx_d   = tx_idx_q;
      tx_shift_d = tx_shift_q;
      tx_d       = tx_q;
      case (tx_state_q)
         S_IDLE: begin
            tx_d = 1'b1;
            if (buf_full_q) begin
               tx_shift_d = buf_data_q;
               tx_cnt_d   = '0;
               tx_state_d = S_START;
               tx_d       = 1'b0;
            end
         end
         S_START: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_idx_d   = '0;
               tx_state_d = S_DATA;
               tx_d       = tx_shift_q[0];
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         S_DATA: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d = '0;
               if (tx_idx_q == IDX_LAST) begin
                  tx_idx_d   = '0;
                  tx_state_d = S_STOP;
                  tx_d       = 1'b1;
               end else begin
                  tx_idx_d   = tx_idx_q + IW'(1);
                  tx_shift_d = {1'b0, tx_shift_q[DATA_BITS-1:1]};
                  tx_d       = tx_shift_q[1];
               end
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         S_STOP: begin
            if (tx_cnt_q == BIT_LAST) begin
               tx_cnt_d   = '0;
               tx_state_d = S_IDLE;
               tx_d       = 1'b1;
            end else begin
               tx_cnt_d = tx_cnt_q + CW'(1);
            end
         end
         default: begin
            tx_state_d = S_IDLE;
            tx_d       = 1'b1;
         end
      endcase
   end

   // ---------------------------------------------------------------
   // control and status registers
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!reset) begin
         rx_meta_q  <= 1'b1;
         rx_sync_q  <= 1'b1;
         rx_state_q <= S_IDLE;
         rx_cnt_q   <= '0;
         rx_idx_q   <= '0;
         rx_ferr_q  <= 1'b0;
         rx_done_q  <= 1'b0;
         led_q      <= '0;
         buf_full_q <= 1'b0;
         tx_state_q <= S_IDLE;
         tx_cnt_q   <= '0;
         tx_idx_q   <= '0;
         tx_q       <= 1'b1;
      end else begin
         rx_meta_q  <= rx;
         rx_sync_q  <= rx_meta_q;
         rx_state_q <= rx_state_d;
         rx_cnt_q   <= rx_cnt_d;
         rx_idx_q   <= rx_idx_d;
         rx_ferr_q  <= rx_ferr_d;
         rx_done_q  <= rx_done_d;
         led_q      <= led_d;
         buf_full_q <= buf_full_d;
         tx_state_q <= tx_state_d;
         tx_cnt_q   <= tx_cnt_d;
         tx_idx_q   <= tx_idx_d;
         tx_q       <= tx_d;
      end
   end

   // ---------------------------------------------------------------
   // data registers; only meaningful while qualified by control state
   // ---------------------------------------------------------------
   always_ff @(posedge clk) begin
      rx_shift_q <= rx_shift_d;
      buf_data_q <= buf_data_d;
      tx_shift_q <= tx_shift_d;
   end

endmodule

// File: tb/tb_tp_final_top.sv
module tb_tp_final_top;

   localparam int CPB = 32;

   logic       clk   = 1'b0;
   logic       reset = 1'b0;
   logic       rx    = 1'b1;
   logic       tx;
   logic [7:0] led;

   int checks = 0;
   int errors = 0;

   always #1 clk = ~clk;

   tp_final_top #(.CLKS_PER_BIT(CPB), .DATA_BITS(8)) dut (
      .clk   (clk),
      .reset (reset),
      .rx    (rx),
      .tx    (tx),
      .led   (led)
   );

   // decoded echo frames: byte, length of the initial low run, start/stop sanity
   logic [7:0] mon_byte_q[$];
   int         mon_run_q[$];
   bit         mon_ok_q[$];

   initial begin : tx_mon
      logic [7:0] b;
      int         run;
      bit         inrun;
      bit         ok;
      int         k;
      forever begin
         @(negedge clk);
         if (tx === 1'b0) begin
            b = '0; run = 0; inrun = 1'b1; ok = 1'b1;
            for (int i = 0; i < 304; i++) begin
               if (i > 0) @(negedge clk);
               if (inrun && tx === 1'b0) run++;
               else inrun = 1'b0;
               if (i % 32 == 15) begin
                  k = i / 32;
                  if (k == 0) ok = ok && (tx === 1'b0);
                  else if (k <= 8) b[k-1] = tx;
                  else ok = ok && (tx === 1'b1);
               end
            end
            mon_byte_q.push_back(b);
            mon_run_q.push_back(run);
            mon_ok_q.push_back(ok);
         end
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   // drive one frame from a negedge; led sampled 16 and 21 clocks into the stop bit
   task automatic send_frame(input logic [7:0] d, input logic stopb,
                             output logic [7:0] led_pre, output logic [7:0] led_post);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         repeat (CPB) @(negedge clk);
      end
      rx = stopb;
      repeat (16) @(negedge clk);
      led_pre = led;
      repeat (5) @(negedge clk);
      led_post = led;
      repeat (CPB - 21) @(negedge clk);
      rx = 1'b1;
   endtask

   task automatic pop_echo(input string tag, input logic [7:0] exp_b, input int exp_run);
      chk({tag, "_present"}, 32'(mon_byte_q.size() > 0), 32'd1);
      if (mon_byte_q.size() > 0) begin
         chk({tag, "_byte"}, 32'(mon_byte_q.pop_front()), 32'(exp_b));
         chk({tag, "_lowrun"}, 32'(mon_run_q.pop_front()), 32'(exp_run));
         chk({tag, "_framing"}, 32'(mon_ok_q.pop_front()), 32'd1);
      end
   endtask

   task automatic count_tx_low(input int n, output int lows);
      lows = 0;
      repeat (n) begin
         @(negedge clk);
         if (tx !== 1'b1) lows++;
      end
   endtask

   initial begin : main
      logic [7:0] pre, post;
      logic [7:0] seq [4];
      int         lows;

      // reset and idle line
      reset = 1'b0; rx = 1'b1;
      @(negedge clk);
      reset = 1'b1;
      chk("rst_led", 32'(led), 32'h00);
      chk("rst_tx", 32'(tx), 32'd1);
      count_tx_low(1000, lows);
      chk("idle_tx_low", 32'(lows), 32'd0);
      chk("idle_led", 32'(led), 32'h00);

      // single frame 0x02
      send_frame(8'h02, 1'b1, pre, post);
      chk("t2_led_pre", 32'(pre), 32'h00);
      chk("t2_led_post", 32'(post), 32'h02);
      idle(1000);
      pop_echo("t2_echo", 8'h02, 64);

      // three 0x02 then 0x01 with long gaps
      seq[0] = 8'h02; seq[1] = 8'h02; seq[2] = 8'h02; seq[3] = 8'h01;
      for (int i = 0; i < 4; i++) begin
         send_frame(seq[i], 1'b1, pre, post);
         chk($sformatf("t3_led%0d", i), 32'(post), 32'(seq[i]));
         idle(4000);
      end
      pop_echo("t3_echo0", 8'h02, 64);
      pop_echo("t3_echo1", 8'h02, 64);
      pop_echo("t3_echo2", 8'h02, 64);
      pop_echo("t3_echo3", 8'h01, 32);

      // short low pulse is a glitch
      rx = 1'b0;
      idle(10);
      rx = 1'b1;
      count_tx_low(1000, lows);
      chk("t4_led", 32'(led), 32'h01);
      chk("t4_tx_low", 32'(lows), 32'd0);
      chk("t4_no_echo", 32'(mon_byte_q.size()), 32'd0);

      // framing error then a good frame
      send_frame(8'h55, 1'b0, pre, post);
      chk("t5_led_ferr", 32'(post), 32'h01);
      idle(1000);
      chk("t5_led_after", 32'(led), 32'h01);
      chk("t5_no_echo", 32'(mon_byte_q.size()), 32'd0);
      send_frame(8'hA5, 1'b1, pre, post);
      chk("t5_led_good", 32'(post), 32'hA5);
      idle(1000);
      pop_echo("t5_echo", 8'hA5, 32);

      // back-to-back frames
      send_frame(8'h11, 1'b1, pre, post);
      chk("bb_led0", 32'(post), 32'h11);
      send_frame(8'h22, 1'b1, pre, post);
      chk("bb_led1", 32'(post), 32'h22);
      idle(2000);
      pop_echo("bb_echo0", 8'h11, 32);
      pop_echo("bb_echo1", 8'h22, 64);

      // reset in the middle of data bit 4 of frame 0xF0
      rx = 1'b0;
      idle(CPB);
      for (int i = 0; i < 4; i++) begin
         rx = 1'b0;
         idle(CPB);
      end
      rx = 1'b1;
      idle(16);
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      chk("t6_rst_led", 32'(led), 32'h00);
      chk("t6_rst_tx", 32'(tx), 32'd1);
      count_tx_low(1000, lows);
      chk("t6_tx_low", 32'(lows), 32'd0);
      chk("t6_led_hold", 32'(led), 32'h00);
      send_frame(8'h3C, 1'b1, pre, post);
      chk("t6_led_good", 32'(post), 32'h3C);
      idle(1000);
      pop_echo("t6_echo", 8'h3C, 96);
      chk("end_no_extra_echo", 32'(mon_byte_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
